// File: rtl/framebuffer_swap_controller.sv
// Double-buffer scheduler: routes SPI pixel writes into the back bank,
// swaps banks on end-of-frame and optionally clears the new back bank.
module framebuffer_swap_controller #(
    parameter int rows          = 8,
    parameter int columns       = 32,
    parameter int bitwidth      = 8,
    parameter int clear_on_swap = 1,
    localparam int RW = (rows > 1) ? $clog2(rows) : 1,
    localparam int CW = (columns > 1) ? $clog2(columns) : 1,
    localparam int PW = 3 * bitwidth
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_wen,
    input  logic [RW-1:0] spi_wrow,
    input  logic [CW-1:0] spi_wcol,
    input  logic [PW-1:0] spi_wdata,
    input  logic          spi_loaded,
    output logic          spi_ready,
    input  logic          frame_end,
    output logic          fb_wen,
    output logic          fb_wbank,
    output logic [RW-1:0] fb_wrow,
    output logic [CW-1:0] fb_wcol,
    output logic [PW-1:0] fb_wdata,
    output logic          fb_rbank,
    output logic [7:0]    swap_count
);

    typedef enum logic [1:0] {FILL, PEND, CLEAR} state_t;

    localparam logic [RW-1:0] ROW_LAST = RW'(rows - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(columns - 1);
    localparam logic          DO_CLEAR = (clear_on_swap != 0);

    state_t        state_q, state_d;
    logic          spi_ready_q, spi_ready_d;
    logic          fb_wen_q, fb_wen_d;
    logic          fb_wbank_q, fb_wbank_d;
    logic          fb_rbank_q, fb_rbank_d;
    logic [RW-1:0] fb_wrow_q, fb_wrow_d;
    logic [CW-1:0] fb_wcol_q, fb_wcol_d;
    logic [PW-1:0] fb_wdata_q, fb_wdata_d;
    logic [7:0]    swap_count_q, swap_count_d;

    always_comb begin
        state_d      = state_q;
        fb_wen_d     = 1'b0;
        fb_wbank_d   = fb_wbank_q;
        fb_rbank_d   = fb_rbank_q;
        fb_wrow_d    = fb_wrow_q;
        fb_wcol_d    = fb_wcol_q;
        fb_wdata_d   = fb_wdata_q;
        swap_count_d = swap_count_q;
        unique case (state_q)
            FILL: begin
                if (spi_wen) begin
                    fb_wen_d   = 1'b1;
                    fb_wrow_d  = spi_wrow;
                    fb_wcol_d  = spi_wcol;
                    fb_wdata_d = spi_wdata;
                end
                if (spi_loaded) state_d = PEND;
            end
            PEND: begin
                if (frame_end) begin
                    fb_rbank_d   = ~fb_rbank_q;
                    fb_wbank_d   = ~fb_wbank_q;
                    swap_count_d = swap_count_q + 8'd1;
                    if (DO_CLEAR) begin
                        state_d    = CLEAR;
                        fb_wen_d   = 1'b1;
                        fb_wrow_d  = '0;
                        fb_wcol_d  = '0;
                        fb_wdata_d = '0;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            CLEAR: begin
                // output row/col registers double as the clear address counter
                if (fb_wrow_q == ROW_LAST && fb_wcol_q == COL_LAST) begin
                    state_d = FILL;
                end else begin
                    fb_wen_d   = 1'b1;
                    fb_wdata_d = '0;
                    if (fb_wcol_q == COL_LAST) begin
                        fb_wcol_d = '0;
                        fb_wrow_d = fb_wrow_q + RW'(1);
                    end else begin
                        fb_wcol_d = fb_wcol_q + CW'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
        spi_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            spi_ready_q  <= 1'b0;
            fb_wen_q     <= 1'b0;
            fb_wbank_q   <= 1'b1;
            fb_rbank_q   <= 1'b0;
            fb_wrow_q    <= '0;
            fb_wcol_q    <= '0;
            fb_wdata_q   <= '0;
            swap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            spi_ready_q  <= spi_ready_d;
            fb_wen_q     <= fb_wen_d;
            fb_wbank_q   <= fb_wbank_d;
            fb_rbank_q   <= fb_rbank_d;
            fb_wrow_q    <= fb_wrow_d;
            fb_wcol_q    <= fb_wcol_d;
            fb_wdata_q   <= fb_wdata_d;
            swap_count_q <= swap_count_d;
        end
    end

    assign spi_ready  = spi_ready_q;
    assign fb_wen     = fb_wen_q;
    assign fb_wbank   = fb_wbank_q;
    assign fb_rbank   = fb_rbank_q;
    assign fb_wrow    = fb_wrow_q;
    assign fb_wcol    = fb_wcol_q;
    assign fb_wdata   = fb_wdata_q;
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_framebuffer_swap_controller.sv
// Bench for framebuffer_swap_controller: two instances (clear on/off) share
// stimulus; a per-cycle model plus hand-computed literal checks.
module tb_framebuffer_swap_controller;

    localparam int R = 8;
    localparam int C = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_wen = 1'b0;
    logic [2:0]  spi_wrow = '0;
    logic [4:0]  spi_wcol = '0;
    logic [23:0] spi_wdata = '0;
    logic        spi_loaded = 1'b0;
    logic        frame_end = 1'b0;

    logic [1:0]        o_ready, o_wen, o_wbank, o_rbank;
    logic [1:0][2:0]   o_row;
    logic [1:0][4:0]   o_col;
    logic [1:0][23:0]  o_data;
    logic [1:0][7:0]   o_sc;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    framebuffer_swap_controller #(
        .rows(R), .columns(C), .bitwidth(8), .clear_on_swap(1)
    ) dut0 (
        .clk(clk), .rst(rst), .spi_wen(spi_wen), .spi_wrow(spi_wrow),
        .spi_wcol(spi_wcol), .spi_wdata(spi_wdata), .spi_loaded(spi_loaded),
        .spi_ready(o_ready[0]), .frame_end(frame_end), .fb_wen(o_wen[0]),
        .fb_wbank(o_wbank[0]), .fb_wrow(o_row[0]), .fb_wcol(o_col[0]),
        .fb_wdata(o_data[0]), .fb_rbank(o_rbank[0]), .swap_count(o_sc[0])
    );

    framebuffer_swap_controller #(
        .rows(R), .columns(C), .bitwidth(8), .clear_on_swap(0)
    ) dut1 (
        .clk(clk), .rst(rst), .spi_wen(spi_wen), .spi_wrow(spi_wrow),
        .spi_wcol(spi_wcol), .spi_wdata(spi_wdata), .spi_loaded(spi_loaded),
        .spi_ready(o_ready[1]), .frame_end(frame_end), .fb_wen(o_wen[1]),
        .fb_wbank(o_wbank[1]), .fb_wrow(o_row[1]), .fb_wcol(o_col[1]),
        .fb_wdata(o_data[1]), .fb_rbank(o_rbank[1]), .swap_count(o_sc[1])
    );

    // model: 0 = accepting writes, 1 = waiting for frame end, 2 = clearing
    int   m_mode [2];
    int   m_idx  [2];
    bit   e_ready [2], e_wen [2], e_rb [2], e_pin [2];
    int   e_row [2], e_col [2], e_data [2], e_sc [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_mode[k] = 0; e_ready[k] = 0; e_wen[k] = 0; e_rb[k] = 0;
                e_sc[k] = 0; e_row[k] = 0; e_col[k] = 0; e_data[k] = 0;
                e_pin[k] = 1;
            end else begin
                e_pin[k] = 0;
                e_wen[k] = 0;
                if (m_mode[k] == 0) begin
                    if (spi_wen) begin
                        e_wen[k] = 1; e_row[k] = spi_wrow;
                        e_col[k] = spi_wcol; e_data[k] = spi_wdata;
                    end
                    if (spi_loaded) m_mode[k] = 1;
                end else if (m_mode[k] == 1) begin
                    if (frame_end) begin
                        e_rb[k] = !e_rb[k];
                        e_sc[k] = (e_sc[k] + 1) % 256;
                        if (k == 0) begin
                            m_mode[k] = 2; m_idx[k] = 0;
                            e_wen[k] = 1; e_row[k] = 0; e_col[k] = 0; e_data[k] = 0;
                        end else begin
                            m_mode[k] = 0;
                        end
                    end
                end else begin
                    m_idx[k] = m_idx[k] + 1;
                    if (m_idx[k] < R * C) begin
                        e_wen[k] = 1; e_row[k] = m_idx[k] / C;
                        e_col[k] = m_idx[k] % C; e_data[k] = 0;
                    end else begin
                        m_mode[k] = 0;
                    end
                end
                e_ready[k] = (m_mode[k] == 0);
            end
        end
    end

    task automatic cmp(string name, int k, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t got %h want %h", name, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            cmp("ready", k, 32'(o_ready[k]), 32'(e_ready[k]));
            cmp("wen", k, 32'(o_wen[k]), 32'(e_wen[k]));
            cmp("rbank", k, 32'(o_rbank[k]), 32'(e_rb[k]));
            cmp("wbank", k, 32'(o_wbank[k]), 32'(!e_rb[k]));
            cmp("swap_count", k, 32'(o_sc[k]), 32'(e_sc[k]));
            if (e_wen[k] || e_pin[k]) begin
                cmp("row", k, 32'(o_row[k]), 32'(e_row[k]));
                cmp("col", k, 32'(o_col[k]), 32'(e_col[k]));
                cmp("data", k, 32'(o_data[k]), 32'(e_data[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        spi_wen = 0; spi_loaded = 0; frame_end = 0;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(int r, int c, int d);
        spi_wen = 1; spi_wrow = 3'(r); spi_wcol = 5'(c); spi_wdata = 24'(d);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (o_ready[0] !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        cmp("wait_ready", 0, 32'(o_ready[0]), 32'd1);
    endtask

    initial begin
        // reset
        ticks(3);
        cmp("rst_ready", 0, 32'(o_ready[0]), 32'd0);
        cmp("rst_wen", 0, 32'(o_wen[0]), 32'd0);
        cmp("rst_rbank", 0, 32'(o_rbank[0]), 32'd0);
        cmp("rst_wbank", 0, 32'(o_wbank[0]), 32'd1);
        cmp("rst_sc", 0, 32'(o_sc[0]), 32'd0);
        rst = 0;
        tick();
        cmp("ready_after_rst", 0, 32'(o_ready[0]), 32'd1);

        // single pixel write
        wr(3, 17, 24'h12ed34);
        tick();
        cmp("w_wen", 0, 32'(o_wen[0]), 32'd1);
        cmp("w_wbank", 0, 32'(o_wbank[0]), 32'd1);
        cmp("w_row", 0, 32'(o_row[0]), 32'd3);
        cmp("w_col", 0, 32'(o_col[0]), 32'd17);
        cmp("w_data", 0, 32'(o_data[0]), 32'h12ed34);
        tick();
        cmp("w_wen_off", 0, 32'(o_wen[0]), 32'd0);

        // loaded at N, frame_end at N+10, writes ignored in PEND/CLEAR
        wr(1, 2, 24'h0000aa);
        spi_loaded = 1;
        tick();
        cmp("pend_ready", 0, 32'(o_ready[0]), 32'd0);
        for (int i = 0; i < 9; i++) begin
            wr(i % R, i, 24'h5a5a00 + i);
            tick();
        end
        frame_end = 1;
        tick();
        cmp("swap_rbank", 0, 32'(o_rbank[0]), 32'd1);
        cmp("swap_wbank", 0, 32'(o_wbank[0]), 32'd0);
        cmp("swap_sc", 0, 32'(o_sc[0]), 32'd1);
        cmp("clr_first", 0, 32'({o_wen[0], o_row[0], o_col[0]}), 32'h100);
        cmp("noclr_ready", 1, 32'(o_ready[1]), 32'd1);
        cmp("noclr_wen", 1, 32'(o_wen[1]), 32'd0);
        for (int i = 0; i < 255; i++) begin
            if (i % 7 == 0) wr(5, 9, 24'hffffff);
            tick();
        end
        cmp("clr_last_wen", 0, 32'(o_wen[0]), 32'd1);
        cmp("clr_last_row", 0, 32'(o_row[0]), 32'd7);
        cmp("clr_last_col", 0, 32'(o_col[0]), 32'd31);
        cmp("clr_last_data", 0, 32'(o_data[0]), 32'd0);
        cmp("clr_last_ready", 0, 32'(o_ready[0]), 32'd0);
        tick();
        cmp("clr_done_ready", 0, 32'(o_ready[0]), 32'd1);
        cmp("clr_done_wen", 0, 32'(o_wen[0]), 32'd0);

        // frame_end in FILL: no swap
        frame_end = 1;
        tick();
        tick();
        cmp("fill_fe_sc", 0, 32'(o_sc[0]), 32'd1);
        cmp("fill_fe_rb", 0, 32'(o_rbank[0]), 32'd1);

        // loaded and frame_end together: pend only
        spi_loaded = 1;
        frame_end = 1;
        tick();
        cmp("lf_ready", 0, 32'(o_ready[0]), 32'd0);
        cmp("lf_rb", 0, 32'(o_rbank[0]), 32'd1);
        cmp("lf_sc", 0, 32'(o_sc[0]), 32'd1);
        ticks(3);
        spi_loaded = 1;
        frame_end = 1;
        tick();
        cmp("lf_swap_sc", 0, 32'(o_sc[0]), 32'd2);
        cmp("lf_swap_rb", 0, 32'(o_rbank[0]), 32'd0);
        wait_ready();

        // run swaps until the counter wraps
        for (int i = 0; i < 254; i++) begin
            spi_loaded = 1;
            tick();
            frame_end = 1;
            tick();
            wait_ready();
        end
        cmp("wrap_sc", 0, 32'(o_sc[0]), 32'd0);
        cmp("wrap_sc1", 1, 32'(o_sc[1]), 32'd0);

        // reset in the middle of a clear
        spi_loaded = 1;
        tick();
        frame_end = 1;
        tick();
        cmp("m1_ready_noclr", 1, 32'(o_ready[1]), 32'd1);
        cmp("m1_sc", 0, 32'(o_sc[0]), 32'd1);
        ticks(99);
        cmp("mid_row", 0, 32'(o_row[0]), 32'd3);
        cmp("mid_col", 0, 32'(o_col[0]), 32'd3);
        rst = 1;
        tick();
        cmp("mid_rst_wen", 0, 32'(o_wen[0]), 32'd0);
        cmp("mid_rst_ready", 0, 32'(o_ready[0]), 32'd0);
        cmp("mid_rst_sc", 0, 32'(o_sc[0]), 32'd0);
        cmp("mid_rst_rb", 0, 32'(o_rbank[0]), 32'd0);
        cmp("mid_rst_wb", 0, 32'(o_wbank[0]), 32'd1);
        cmp("mid_rst_row", 0, 32'(o_row[0]), 32'd0);
        rst = 0;
        tick();
        cmp("post_rst_ready", 0, 32'(o_ready[0]), 32'd1);
        cmp("post_rst_wen", 0, 32'(o_wen[0]), 32'd0);
        ticks(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
